// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: the core has fixed priority, a starvation
// counter guarantees the DMA a slot, and a lock input lets the DMA hold a burst.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    output logic              c_gnt_o,
    output logic              c_stall_o,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic              d_lock_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,

    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] DLOCK = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             starve;
    logic             c_gnt;
    logic             d_gnt;
    logic             c_rd;
    logic             d_rd;

    assign starve = (wait_cnt == WAIT_LIMIT);

    // Grant selection, lock tracking and starvation counter update
    always_comb begin
        state_nxt    = state;
        c_gnt        = 1'b0;
        d_gnt        = 1'b0;
        wait_cnt_nxt = wait_cnt;

        case (state)
            ARB: begin
                c_gnt = c_req_i & ~starve;
                d_gnt = d_req_i & ~c_gnt;
                if (d_gnt && d_lock_i) begin
                    state_nxt = DLOCK;
                end
            end
            DLOCK: begin
                d_gnt = d_req_i;
                // Dropping the request while locked releases the memory too
                if (!d_lock_i || !d_req_i) begin
                    state_nxt = ARB;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase

        if (rst_i) begin
            c_gnt = 1'b0;
            d_gnt = 1'b0;
        end

        if (!d_req_i || d_gnt) begin
            wait_cnt_nxt = '0;
        end else if (wait_cnt < WAIT_LIMIT) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end

    assign c_gnt_o   = c_gnt;
    assign d_gnt_o   = d_gnt;
    assign c_stall_o = c_req_i & ~c_gnt;
    assign c_rd      = c_gnt & ~c_we_i;
    assign d_rd      = d_gnt & ~d_we_i;

    // Memory port mux; an idle port is driven to zero
    always_comb begin
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (c_gnt) begin
            mem_we_o    = c_we_i;
            mem_re_o    = ~c_we_i;
            mem_addr_o  = c_addr_i;
            mem_wdata_o = c_wdata_i;
        end else if (d_gnt) begin
            mem_we_o    = d_we_i;
            mem_re_o    = ~d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    // State, counter and one-cycle-latency read return
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ARB;
            wait_cnt   <= '0;
            c_rvalid_o <= 1'b0;
            d_rvalid_o <= 1'b0;
            c_rdata_o  <= '0;
            d_rdata_o  <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            c_rvalid_o <= c_rd;
            d_rvalid_o <= d_rd;
            if (c_rd) begin
                c_rdata_o <= mem_rdata_i;
            end
            if (d_rd) begin
                d_rdata_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline MEM stage (core port, c_) and the DMA/debug loader (dma port, d_). The core has fixed priority. A starvation counter guarantees the DMA a slot, and a lock input lets the DMA hold the memory for back-to-back bursts. The block drives the memory's WE/RE/address/write-data inputs, registers read data back to the winning requester, and tells the pipeline when to stall.

Parameters:
ADDR_W, 10, word address width; matches the memory index width.
DATA_W, 32, data word width.
MAX_WAIT, 4, cycles a pending DMA request may be refused before it takes priority; legal range 1..255.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous active-high reset.
c_req_i  in  1  core access request.
c_we_i  in  1  core write (1) / read (0).
c_addr_i  in  ADDR_W  core word address.
c_wdata_i  in  DATA_W  core write data.
c_gnt_o  out  1  core granted this cycle.
c_stall_o  out  1  c_req_i & ~c_gnt_o.
c_rvalid_o  out  1  core read data valid.
c_rdata_o  out  DATA_W  core read data.
d_req_i  in  1  DMA access request.
d_we_i  in  1  DMA write / read.
d_lock_i  in  1  DMA requests to keep ownership after its current grant.
d_addr_i  in  ADDR_W  DMA word address.
d_wdata_i  in  DATA_W  DMA write data.
d_gnt_o  out  1  DMA granted this cycle.
d_rvalid_o  out  1  DMA read data valid.
d_rdata_o  out  DATA_W  DMA read data.
mem_we_o  out  1  memory write enable.
mem_re_o  out  1  memory read enable.
mem_addr_o  out  ADDR_W  memory address.
mem_wdata_o  out  DATA_W  memory write data.
mem_rdata_i  in  DATA_W  memory read data; combinational from mem_addr_o.

Behaviour:
- State machine with two states: ARB and DLOCK. Reset state is ARB.
- Grant logic (combinational, same-cycle accept):
  - In ARB, c_gnt_o = c_req_i & ~starve. d_gnt_o = d_req_i & ~c_gnt_o.
  - starve = (wait_cnt == MAX_WAIT).
  - In DLOCK, d_gnt_o = d_req_i and c_gnt_o = 0.
  - At most one grant is active per cycle.
  - While rst_i = 1, both grants, mem_we_o and mem_re_o are 0.
- Memory mux:
  - The granted port drives mem_addr_o and mem_wdata_o.
  - mem_we_o = granted & we. mem_re_o = granted & ~we.
  - With no grant, addr and wdata are 0 and both enables are 0.
  - Writes commit at the rising edge ending the grant cycle.
- Read return:
  - On a granted read, mem_rdata_i is registered into that port's rdata at the next edge.
  - The matching rvalid is high for exactly 1 cycle after the grant; read latency = 1.
  - rdata holds its last value otherwise.
  - Writes never assert rvalid.
- wait_cnt (8 bits):
  - Clears to 0 on a DMA grant, or when d_req_i = 0.
  - Increments when d_req_i = 1 and d_gnt_o = 0, saturating at MAX_WAIT.
  - When saturated, the next cycle grants the DMA even if the core requests; the core stalls that cycle.
- Transitions:
  - ARB -> DLOCK when d_gnt_o & d_lock_i.
  - DLOCK -> ARB when d_lock_i = 0, or when d_req_i = 0 (the DMA dropped its request while locked; this prevents deadlock).
  - DLOCK -> DLOCK otherwise.
- c_stall_o is high whenever the core requests and is refused, including the whole DLOCK period.
- Reset mid-operation:
  - All registered outputs clear: rvalid 0, rdata 0, wait_cnt 0, state ARB.
  - A read granted in the cycle rst_i rises produces no rvalid.
- Same-address core write and DMA read in the same cycle cannot happen, because only one grant is issued. Ordering is purely by grant order.

Test Plan:
1. Reset: hold rst_i 2 cycles with c_req_i = d_req_i = 1 -> both gnt 0, rvalid 0, rdata 0, mem_we_o = mem_re_o = 0.
2. Core write then read: c write addr 0x005 data 0xDEADBEEF, next cycle c read 0x005 -> c_gnt_o = 1 both cycles; c_rvalid_o = 1 one cycle later with c_rdata_o = 0xDEADBEEF; d_rvalid_o stays 0.
3. Contention: c_req_i and d_req_i held high, MAX_WAIT = 4 -> core granted 4 cycles; DMA granted on the 5th with c_stall_o = 1; wait_cnt returns to 0; the pattern repeats.
4. DMA lock burst: d writes 0x10..0x13 with d_lock_i = 1 while c_req_i = 1 -> 4 consecutive d_gnt_o, c_stall_o = 1 throughout; core granted the cycle after d_lock_i drops.
5. Lock abandon: enter DLOCK, then drop d_req_i with d_lock_i still 1 -> return to ARB next cycle; waiting core granted.
6. Reset mid-read: DMA read granted in the cycle rst_i asserts -> d_rvalid_o stays 0, state ARB, wait_cnt 0.
